// File: rtl/ab_burst_arbiter_pkg.sv
// ab_arb_pkg: state/owner types and default burst length shared by the burst arbiter files
package ab_arb_pkg;
  localparam int BURST_LEN_DEF = 4;
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    BURST_A = 3'd1,
    BURST_B = 3'd2,
    GAP_A   = 3'd3,
    GAP_B   = 3'd4
  } state_t;
  typedef enum logic {OWNER_A = 1'b0, OWNER_B = 1'b1} owner_t;
endpackage

// File: rtl/ab_burst_arbiter_if.sv
// ab_burst_arbiter_if: requester/resource handshake bundle; master drives requests, slave is the arbiter
interface ab_burst_arbiter_if import ab_arb_pkg::*; #(
  parameter int BURST_LEN = BURST_LEN_DEF
);
  localparam int CNT_W = $clog2(BURST_LEN);
  logic req_a, req_b, beat_ack;
  logic gnt_a, gnt_b, last, busy, done_a, done_b, abort;
  logic [CNT_W-1:0] beat_idx;
  modport master (
    output req_a, req_b, beat_ack,
    input  gnt_a, gnt_b, beat_idx, last, busy, done_a, done_b, abort
  );
  modport slave (
    input  req_a, req_b, beat_ack,
    output gnt_a, gnt_b, beat_idx, last, busy, done_a, done_b, abort
  );
endinterface

// File: rtl/ab_burst_arbiter_beat_counter.sv
// ab_beat_counter: beat index within a burst with increment, clear and last-beat detect
module ab_beat_counter import ab_arb_pkg::*; #(
  parameter int BURST_LEN = BURST_LEN_DEF,
  localparam int CNT_W = $clog2(BURST_LEN)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clear,
  output logic [CNT_W-1:0] idx,
  output logic             last
);
  always_ff @(posedge clk or posedge reset)
    if (reset) idx <= '0;
    else if (clear) idx <= '0;
    else if (inc) idx <= idx + CNT_W'(1);
  assign last = idx == CNT_W'(BURST_LEN - 1);
endmodule

// File: rtl/ab_burst_arbiter.sv
// ab_burst_arbiter: round-robin A/B arbiter granting whole BURST_LEN-beat bursts (Moore outputs).
// Define ARB_ABORT_EN to let a requester abandon its burst by dropping its request while stalled.
module ab_burst_arbiter import ab_arb_pkg::*; #(
  parameter int BURST_LEN = BURST_LEN_DEF
) (
  input logic clk,
  input logic reset,
  ab_burst_arbiter_if.slave bus
);
  localparam int CNT_W = $clog2(BURST_LEN);
  state_t state, state_d;
  owner_t last_owner;
  logic [CNT_W-1:0] idx;
  logic cnt_last, in_burst, fin, abort_go, to_gap, pick_a, abort_q;
  assign in_burst = state == BURST_A || state == BURST_B;
  assign fin = in_burst && bus.beat_ack && cnt_last;
`ifdef ARB_ABORT_EN
  assign abort_go = in_burst && !bus.beat_ack && !(state == BURST_A ? bus.req_a : bus.req_b);
`else
  assign abort_go = 1'b0;
`endif
  assign to_gap = fin || abort_go;
  assign pick_a = bus.req_a && (!bus.req_b || last_owner == OWNER_B);
  // GAP and any unused encoding fall back to IDLE
  always_comb begin
    state_d = state;
    if (state == IDLE) state_d = pick_a ? BURST_A : bus.req_b ? BURST_B : IDLE;
    else if (!in_burst) state_d = IDLE;
    else if (to_gap) state_d = state == BURST_A ? GAP_A : GAP_B;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state      <= IDLE;
      last_owner <= OWNER_B;
      abort_q    <= 1'b0;
    end else begin
      state   <= state_d;
      abort_q <= abort_go;
      if (to_gap) last_owner <= state == BURST_A ? OWNER_A : OWNER_B;
    end
  ab_beat_counter #(.BURST_LEN(BURST_LEN)) u_cnt (
    .clk(clk),
    .reset(reset),
    .inc(in_burst && bus.beat_ack && !cnt_last),
    .clear(to_gap),
    .idx(idx),
    .last(cnt_last)
  );
  assign bus.gnt_a    = state == BURST_A;
  assign bus.gnt_b    = state == BURST_B;
  assign bus.beat_idx = idx;
  assign bus.last     = in_burst && cnt_last;
  assign bus.busy     = state != IDLE;
  assign bus.done_a   = state == GAP_A && !abort_q;
  assign bus.done_b   = state == GAP_B && !abort_q;
  assign bus.abort    = abort_q;
endmodule

// File: tb/tb_ab_burst_arbiter.sv
// tb_ab_burst_arbiter: scoreboard bench for ab_burst_arbiter with BURST_LEN = 4
module tb_ab_burst_arbiter;
  logic clk = 1'b0;
  logic reset;
  int checks = 0;
  int errors = 0;
  logic [8:0] sb[$];
  always #5 clk = ~clk;
  ab_burst_arbiter_if #(.BURST_LEN(4)) bus ();
  ab_burst_arbiter #(.BURST_LEN(4)) dut (.clk(clk), .reset(reset), .bus(bus));
  task automatic check(input string tag, input logic [8:0] got, input logic [8:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %03h expected %03h at %0t", tag, got, exp, $time);
    end
  endtask
  // packed view: {gnt_a, gnt_b, beat_idx[1:0], last, busy, done_a, done_b, abort}
  function automatic logic [8:0] ev(logic ga, logic gb, logic [1:0] idx, logic lst,
                                    logic bsy, logic da, logic db, logic ab);
    return {ga, gb, idx, lst, bsy, da, db, ab};
  endfunction
  function automatic logic [8:0] obs();
    return {bus.gnt_a, bus.gnt_b, bus.beat_idx, bus.last, bus.busy, bus.done_a, bus.done_b, bus.abort};
  endfunction
  always @(negedge clk) check("mutex", 9'(bus.gnt_a & bus.gnt_b), 9'd0);
  task automatic cyc(input logic ra, input logic rb, input logic ack,
                     input logic [8:0] exp, input string tag);
    bus.req_a = ra;
    bus.req_b = rb;
    bus.beat_ack = ack;
    sb.push_back(exp);
    @(posedge clk);
    #1;
    check(tag, obs(), sb.pop_front());
  endtask
  // one full burst with ack every cycle: IDLE sample, 4 beats, GAP, IDLE
  task automatic run_burst(input logic own_b, input logic ra, input logic rb);
    for (int i = 0; i < 4; i++)
      cyc(ra, rb, 1'b1, ev(!own_b, own_b, 2'(i), i == 3, 1'b1, 1'b0, 1'b0, 1'b0), own_b ? "beat_b" : "beat_a");
    cyc(ra, rb, 1'b1, ev(1'b0, 1'b0, 2'd0, 1'b0, 1'b1, !own_b, own_b, 1'b0), "gap");
    cyc(ra, rb, 1'b1, ev(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), "idle");
  endtask
  initial begin
    reset = 1'b1;
    bus.req_a = 1'b0;
    bus.req_b = 1'b0;
    bus.beat_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset", obs(), 9'd0);
    @(negedge clk);
    reset = 1'b0;
    run_burst(1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 9'd0, "quiet");
    // last_owner is A, so contention starts with B and alternates
    run_burst(1'b1, 1'b1, 1'b1);
    run_burst(1'b0, 1'b1, 1'b1);
    run_burst(1'b1, 1'b1, 1'b1);
    run_burst(1'b0, 1'b1, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 9'd0, "quiet");
    cyc(1'b0, 1'b1, 1'b1, ev(0, 1, 2'd0, 0, 1, 0, 0, 0), "stall_g");
    cyc(1'b0, 1'b1, 1'b1, ev(0, 1, 2'd1, 0, 1, 0, 0, 0), "stall_1");
    for (int i = 0; i < 10; i++)
      cyc(1'b0, 1'b1, 1'b0, ev(0, 1, 2'd1, 0, 1, 0, 0, 0), "stall_hold");
    cyc(1'b0, 1'b1, 1'b1, ev(0, 1, 2'd2, 0, 1, 0, 0, 0), "stall_2");
    cyc(1'b0, 1'b1, 1'b1, ev(0, 1, 2'd3, 1, 1, 0, 0, 0), "stall_3");
    cyc(1'b0, 1'b1, 1'b1, ev(0, 0, 2'd0, 0, 1, 0, 1, 0), "stall_done");
    cyc(1'b0, 1'b0, 1'b0, 9'd0, "stall_idle");
    cyc(1'b1, 1'b0, 1'b1, ev(1, 0, 2'd0, 0, 1, 0, 0, 0), "late_0");
    cyc(1'b1, 1'b0, 1'b1, ev(1, 0, 2'd1, 0, 1, 0, 0, 0), "late_1");
    cyc(1'b1, 1'b0, 1'b1, ev(1, 0, 2'd2, 0, 1, 0, 0, 0), "late_2");
    cyc(1'b1, 1'b1, 1'b1, ev(1, 0, 2'd3, 1, 1, 0, 0, 0), "late_3");
    cyc(1'b1, 1'b1, 1'b1, ev(0, 0, 2'd0, 0, 1, 1, 0, 0), "late_gap");
    cyc(1'b1, 1'b1, 1'b1, ev(0, 0, 2'd0, 0, 0, 0, 0, 0), "late_idle");
    run_burst(1'b1, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 1'b1, ev(1, 0, 2'd0, 0, 1, 0, 0, 0), "drop_0");
    cyc(1'b1, 1'b0, 1'b1, ev(1, 0, 2'd1, 0, 1, 0, 0, 0), "drop_1");
`ifdef ARB_ABORT_EN
    cyc(1'b0, 1'b0, 1'b0, ev(0, 0, 2'd0, 0, 1, 0, 0, 1), "abort");
    cyc(1'b0, 1'b0, 1'b0, 9'd0, "abort_idle");
`else
    cyc(1'b0, 1'b0, 1'b0, ev(1, 0, 2'd1, 0, 1, 0, 0, 0), "noabort_hold");
    cyc(1'b0, 1'b0, 1'b1, ev(1, 0, 2'd2, 0, 1, 0, 0, 0), "noabort_2");
    cyc(1'b0, 1'b0, 1'b1, ev(1, 0, 2'd3, 1, 1, 0, 0, 0), "noabort_3");
    cyc(1'b0, 1'b0, 1'b1, ev(0, 0, 2'd0, 0, 1, 1, 0, 0), "noabort_done");
    cyc(1'b0, 1'b0, 1'b0, 9'd0, "noabort_idle");
`endif
    run_burst(1'b1, 1'b1, 1'b1);
    cyc(1'b1, 1'b0, 1'b1, ev(1, 0, 2'd0, 0, 1, 0, 0, 0), "rst_0");
    cyc(1'b1, 1'b0, 1'b1, ev(1, 0, 2'd1, 0, 1, 0, 0, 0), "rst_1");
    cyc(1'b1, 1'b0, 1'b1, ev(1, 0, 2'd2, 0, 1, 0, 0, 0), "rst_2");
    #3;
    reset = 1'b1;
    #1;
    check("rst_async_gnt", 9'(bus.gnt_a), 9'd0);
    check("rst_async_idx", 9'(bus.beat_idx), 9'd0);
    check("rst_async_busy", 9'(bus.busy), 9'd0);
    @(posedge clk);
    #1;
    check("rst_hold", obs(), 9'd0);
    @(negedge clk);
    reset = 1'b0;
    run_burst(1'b0, 1'b1, 1'b1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ab_burst_arbiter.md
Name: ab_burst_arbiter

Overview:
- Moore-style arbiter sharing one burst-oriented resource between requester A and requester B.
- Grants whole bursts of BURST_LEN beats and counts the beats the resource accepts.
- Alternates owners round-robin when both requesters contend.
- Sits in front of the A/B sequence datapath: the owner's beats are advanced only while that owner holds the grant.

Parameters:
- BURST_LEN, 4, number of accepted beats per burst; legal range 2..256.
- CNT_W, $clog2(BURST_LEN), width of the beat index; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- req_a  input  1  requester A wants a burst; level, held until done_a.
- req_b  input  1  requester B wants a burst; level, held until done_b.
- beat_ack  input  1  resource accepted the current beat this cycle; ignored outside BURST states.
- gnt_a  output  1  A owns the resource.
- gnt_b  output  1  B owns the resource.
- beat_idx  output  CNT_W  index of the current beat within the burst, 0..BURST_LEN-1.
- last  output  1  high when beat_idx == BURST_LEN-1 while granted.
- busy  output  1  state != IDLE.
- done_a  output  1  one-cycle pulse: A's burst completed.
- done_b  output  1  one-cycle pulse: B's burst completed.
- abort  output  1  one-cycle pulse: burst ended early (see Optional Feature).

Behaviour:
- States: IDLE, BURST_A, BURST_B, GAP_A, GAP_B. Encoding lives in the package.
- All outputs are registered or decoded only from state, beat_idx and last_owner (Moore); no input-to-output combinational path.
- Reset (asynchronous, any time including mid-burst) forces:
  - state = IDLE, beat_idx = 0, last_owner = B;
  - all grants, done and abort outputs = 0.
  - A therefore wins the first contention.
- IDLE transitions:
  - only req_a -> BURST_A; only req_b -> BURST_B.
  - both -> the requester that is not last_owner; neither -> stay.
  - Grant is visible on the cycle after the request is sampled (1-cycle latency).
- BURST_x:
  - gnt_x = 1; the other grant = 0; gnt_a and gnt_b are never high together.
  - beat_ack with beat_idx < BURST_LEN-1: beat_idx increments.
  - beat_ack with beat_idx == BURST_LEN-1: go to GAP_x, beat_idx <= 0, last_owner <= x.
  - no beat_ack: hold state and beat_idx indefinitely; no timeout.
  - Requests, including the other requester's, are ignored mid-burst.
- GAP_x:
  - lasts exactly one cycle; done_x = 1; no grants; always returns to IDLE.
  - Minimum spacing between two bursts is two non-granted cycles (GAP, IDLE).
- beat_idx is 0 whenever no grant is active; it never wraps past BURST_LEN-1.
- A request deasserted in IDLE before it is granted is simply dropped.

Optional Feature:
- Macro: ARB_ABORT_EN.
- Defined:
  - In BURST_x, if req_x is low and beat_ack is low, go to GAP_x with abort = 1 and done_x = 0.
  - beat_idx <= 0 and last_owner <= x, so the abort still counts for fairness.
  - If beat_ack and a dropped req occur in the same cycle, the beat is counted first; the abort is evaluated on the next cycle.
- Undefined:
  - req_x is ignored mid-burst, and abort is tied to 0.
  - The port stays present so integration is identical in both builds.

Decomposition:
- Package ab_arb_pkg holds:
  - the state enum typedef (3-bit);
  - the owner typedef (OWNER_A / OWNER_B);
  - the default BURST_LEN localparam.
- One sub-module, ab_beat_counter: a CNT_W-bit counter with inc, clear and last-detect.
  - The FSM drives inc/clear; the counter returns last.
- The FSM, round-robin register and output decode stay in ab_burst_arbiter.

Test Plan:
- Reset mid-burst: BURST_A at beat_idx = 2, assert reset asynchronously -> gnt_a drops before the next edge, beat_idx = 0, state IDLE; the next req_a + req_b grants A.
- Single requester: req_a held, beat_ack every cycle -> gnt_a on cycle 1; beat_idx 0,1,2,3; last on beat 3; done_a one cycle after beat 3; gnt_a = 0 during GAP and IDLE.
- Contention: req_a = req_b = 1 continuously, beat_ack always 1 -> grant sequence A, B, A, B, with exactly 2 non-granted cycles between bursts; gnt_a & gnt_b never both 1.
- Stall: during BURST_B hold beat_ack = 0 for 10 cycles at beat_idx = 1 -> beat_idx stays 1, gnt_b stays 1, no done_b; resume -> completes after 3 more acks.
- Late request: req_b rises during BURST_A beat 2 -> B granted only after GAP_A + IDLE, not before done_a.
- ARB_ABORT_EN: drop req_a at beat_idx = 1 with beat_ack = 0 -> abort = 1 for one cycle, done_a = 0, next contention grants B. Without the macro -> abort stays 0 and the burst waits for 4 acks.
